// File: rtl/arm_shift_pkg.sv
// Shared types for the ARM operand-2 barrel shifter pipeline.
package arm_shift_pkg;

    // Shift type field as encoded in the ARM shifter operand
    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } shift_type_e;

    // Encoding of the in_reg_mode bit (how the shift amount is specified)
    localparam logic RM_IMM = 1'b0;
    localparam logic RM_REG = 1'b1;

endpackage

// File: rtl/arm_shifter_pipe_if.sv
// Operation/result bus for arm_shifter_pipe. The master drives operations
// and consumes results; the slave is the shifter pipeline itself.
interface arm_shifter_pipe_if #(
    parameter int DATA_W = 32,
    parameter int AMT_W  = 8,
    parameter int TAG_W  = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [1:0]        in_type;
    logic [AMT_W-1:0]  in_amt;
    logic              in_reg_mode;
    logic              in_cin;
    logic [TAG_W-1:0]  in_tag;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_cout;
    logic [TAG_W-1:0]  out_tag;
    logic              out_zero;
    logic              out_neg;

    modport master (
        output in_valid, in_data, in_type, in_amt, in_reg_mode, in_cin, in_tag,
        output out_ready,
        input  in_ready,
        input  out_valid, out_data, out_cout, out_tag, out_zero, out_neg
    );

    modport slave (
        input  in_valid, in_data, in_type, in_amt, in_reg_mode, in_cin, in_tag,
        input  out_ready,
        output in_ready,
        output out_valid, out_data, out_cout, out_tag, out_zero, out_neg
    );

endinterface

// File: rtl/arm_shift_core.sv
// Combinational ARM shifter-operand evaluator. A single log2-stage right
// shifter handles every shift type: LSL is done by bit-reversing the operand
// around the network, ASR/ROR differ only in what is fed in from the top.
// A guard bit below the operand catches the last bit shifted out (carry).
module arm_shift_core
    import arm_shift_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int AMT_W  = 8
) (
    input  logic [DATA_W-1:0] data,
    input  shift_type_e       sh_type,
    input  logic [AMT_W-1:0]  amt,
    input  logic              reg_mode,
    input  logic              cin,
    output logic [DATA_W-1:0] result,
    output logic              cout
);

    localparam int LW = $clog2(DATA_W);
    localparam logic [AMT_W-1:0] AMT_FULL = AMT_W'(DATA_W);

    logic [LW-1:0]     amt_lo;
    logic              amt_lo_zero;
    logic              amt_hi_nz;
    logic [DATA_W-1:0] data_rev;
    logic [DATA_W-1:0] fill;
    logic [DATA_W-1:0] src;
    logic [2*DATA_W:0] net;
    logic [DATA_W-1:0] shifted;
    logic              shifted_c;
    logic              unused_net;

    // Barrel network: {fill, operand, guard} shifted right by amt[LW-1:0]
    always_comb begin
        amt_lo      = amt[LW-1:0];
        amt_lo_zero = (amt_lo == '0);
        amt_hi_nz   = |amt[AMT_W-1:LW];

        for (int i = 0; i < DATA_W; i++) begin
            data_rev[i] = data[DATA_W-1-i];
        end

        case (sh_type)
            SH_ASR:  fill = {DATA_W{data[DATA_W-1]}};
            SH_ROR:  fill = data;
            default: fill = '0;
        endcase

        src = (sh_type == SH_LSL) ? data_rev : data;
        net = {fill, src, 1'b0};
        for (int k = 0; k < LW; k++) begin
            if (amt_lo[k]) begin
                net = net >> (1 << k);
            end
        end

        shifted_c  = net[0];
        unused_net = ^net[2*DATA_W:DATA_W+1];
        for (int i = 0; i < DATA_W; i++) begin
            shifted[i] = (sh_type == SH_LSL) ? net[DATA_W-i] : net[i+1];
        end
    end

    // Special amounts (zero, full width, beyond width) override the network
    always_comb begin
        result = shifted;
        cout   = shifted_c;
        if (reg_mode == RM_REG) begin
            if (amt == '0) begin
                result = data;
                cout   = cin;
            end else begin
                case (sh_type)
                    SH_LSL: begin
                        if (amt_hi_nz) begin
                            result = '0;
                            cout   = (amt == AMT_FULL) ? data[0] : 1'b0;
                        end
                    end
                    SH_LSR: begin
                        if (amt_hi_nz) begin
                            result = '0;
                            cout   = (amt == AMT_FULL) ? data[DATA_W-1] : 1'b0;
                        end
                    end
                    SH_ASR: begin
                        if (amt_hi_nz) begin
                            result = fill;
                            cout   = data[DATA_W-1];
                        end
                    end
                    default: begin
                        if (amt_lo_zero) begin
                            result = data;
                            cout   = data[DATA_W-1];
                        end
                    end
                endcase
            end
        end else begin
            if (amt_lo_zero) begin
                case (sh_type)
                    SH_LSL: begin
                        result = data;
                        cout   = cin;
                    end
                    SH_LSR: begin
                        result = '0;
                        cout   = data[DATA_W-1];
                    end
                    SH_ASR: begin
                        result = fill;
                        cout   = data[DATA_W-1];
                    end
                    default: begin
                        result = {cin, data[DATA_W-1:1]};
                        cout   = data[0];
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/arm_shifter_pipe.sv
// Two-stage ARM operand-2 shifter with valid/ready on both sides.
// Stage 1 registers the operation, stage 2 evaluates it through
// arm_shift_core and registers the result, so results leave two clock edges
// after acceptance. Optional result flags: define ARM_SHIFTER_FLAGS_EN to
// build out_zero/out_neg; otherwise both are tied to 0.
module arm_shifter_pipe
    import arm_shift_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int AMT_W  = 8,
    parameter int TAG_W  = 4
) (
    input logic               clk,
    input logic               rst_n,
    arm_shifter_pipe_if.slave bus
);

    logic              s1_load, s2_load;

    logic              s1_valid_d, s1_valid_q;
    logic [DATA_W-1:0] s1_data_d, s1_data_q;
    shift_type_e       s1_type_d, s1_type_q;
    logic [AMT_W-1:0]  s1_amt_d, s1_amt_q;
    logic              s1_reg_mode_d, s1_reg_mode_q;
    logic              s1_cin_d, s1_cin_q;
    logic [TAG_W-1:0]  s1_tag_d, s1_tag_q;

    logic              s2_valid_d, s2_valid_q;
    logic [DATA_W-1:0] s2_data_d, s2_data_q;
    logic              s2_cout_d, s2_cout_q;
    logic [TAG_W-1:0]  s2_tag_d, s2_tag_q;

    logic [DATA_W-1:0] core_result;
    logic              core_cout;

    // A stage may load when it is empty or the stage after it is moving
    always_comb begin
        s2_load = !s2_valid_q || bus.out_ready;
        s1_load = !s1_valid_q || s2_load;
    end

    assign bus.in_ready  = s1_load;
    assign bus.out_valid = s2_valid_q;
    assign bus.out_data  = s2_data_q;
    assign bus.out_cout  = s2_cout_q;
    assign bus.out_tag   = s2_tag_q;

    // Stage 1 next state: capture a new operation whenever the slot frees up
    always_comb begin
        s1_valid_d    = s1_valid_q;
        s1_data_d     = s1_data_q;
        s1_type_d     = s1_type_q;
        s1_amt_d      = s1_amt_q;
        s1_reg_mode_d = s1_reg_mode_q;
        s1_cin_d      = s1_cin_q;
        s1_tag_d      = s1_tag_q;
        if (s1_load) begin
            s1_valid_d = bus.in_valid;
            if (bus.in_valid) begin
                s1_data_d     = bus.in_data;
                s1_type_d     = shift_type_e'(bus.in_type);
                s1_amt_d      = bus.in_amt;
                s1_reg_mode_d = bus.in_reg_mode;
                s1_cin_d      = bus.in_cin;
                s1_tag_d      = bus.in_tag;
            end
        end
    end

    // Stage 1 registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q    <= 1'b0;
            s1_data_q     <= '0;
            s1_type_q     <= SH_LSL;
            s1_amt_q      <= '0;
            s1_reg_mode_q <= 1'b0;
            s1_cin_q      <= 1'b0;
            s1_tag_q      <= '0;
        end else begin
            s1_valid_q    <= s1_valid_d;
            s1_data_q     <= s1_data_d;
            s1_type_q     <= s1_type_d;
            s1_amt_q      <= s1_amt_d;
            s1_reg_mode_q <= s1_reg_mode_d;
            s1_cin_q      <= s1_cin_d;
            s1_tag_q      <= s1_tag_d;
        end
    end

    arm_shift_core #(
        .DATA_W (DATA_W),
        .AMT_W  (AMT_W)
    ) u_core (
        .data     (s1_data_q),
        .sh_type  (s1_type_q),
        .amt      (s1_amt_q),
        .reg_mode (s1_reg_mode_q),
        .cin      (s1_cin_q),
        .result   (core_result),
        .cout     (core_cout)
    );

    // Stage 2 next state: results only change when the consumer lets them go
    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_cout_d  = s2_cout_q;
        s2_tag_d   = s2_tag_q;
        if (s2_load) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_data_d = core_result;
                s2_cout_d = core_cout;
                s2_tag_d  = s1_tag_q;
            end
        end
    end

    // Stage 2 registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_cout_q  <= 1'b0;
            s2_tag_q   <= '0;
        end else begin
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_cout_q  <= s2_cout_d;
            s2_tag_q   <= s2_tag_d;
        end
    end

`ifdef ARM_SHIFTER_FLAGS_EN
    logic zero_d, zero_q;
    logic neg_d, neg_q;

    // Result flags follow the stage-2 result, holding with it under stall
    always_comb begin
        zero_d = zero_q;
        neg_d  = neg_q;
        if (s2_load && s1_valid_q) begin
            zero_d = (core_result == '0);
            neg_d  = core_result[DATA_W-1];
        end
    end

    // Result flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
        end else begin
            zero_q <= zero_d;
            neg_q  <= neg_d;
        end
    end

    assign bus.out_zero = zero_q;
    assign bus.out_neg  = neg_q;
`else
    assign bus.out_zero = 1'b0;
    assign bus.out_neg  = 1'b0;
`endif

endmodule

// File: doc/arm_shifter_pipe.md
Name: arm_shifter_pipe

Overview:
- Parametrised, pipelined ARM barrel shifter for the execute stage's operand-2 path.
- Implements full ARM shifter-operand semantics for both encodings:
  - immediate-amount encoding, including LSR/ASR #32 and RRX;
  - register-amount encoding, using the 8-bit amount rules.
- Produces the shifter carry-out.
- Fixed two-stage pipeline with valid/ready handshakes, so it can sit between the register-read and ALU stages with backpressure.

Parameters:
- DATA_W, 32, operand width; must be a power of two, ≥ 8.
- AMT_W, 8, shift-amount width; must satisfy AMT_W > log2(DATA_W).
- TAG_W, 4, width of the sideband tag carried alongside each operation unchanged.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input operation valid.
- in_ready  out  1  block can accept an operation this cycle.
- in_data  in  DATA_W  operand to shift.
- in_type  in  2  shift type: 00 LSL, 01 LSR, 10 ASR, 11 ROR.
- in_amt  in  AMT_W  shift amount.
- in_reg_mode  in  1  amount encoding: 1 = register-specified, 0 = immediate.
- in_cin  in  1  current C flag.
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  DATA_W  shifted result.
- out_cout  out  1  shifter carry-out.
- out_tag  out  TAG_W  tag of the result.
- out_zero  out  1  result is all-zero (optional feature).
- out_neg  out  1  result MSB (optional feature).

Behaviour:
- Reset: s1_valid, s2_valid and out_valid clear immediately on rst_n low. Every data, tag and flag register resets to 0.
- Pipeline:
  - Stage 1 registers the inputs.
  - Stage 2 computes the result through arm_shift_core and registers it.
  - Latency: an input accepted at edge T gives out_valid at edge T+2.
  - Throughput is 1 per cycle when out_ready is high.
- Advance rules:
  - s2_load = !s2_valid || out_ready.
  - s1_load = !s1_valid || s2_load.
  - in_ready = s1_load. This is a combinational path from out_ready, and it is permitted.
  - When out_valid && !out_ready, out_data, out_cout and out_tag hold stable.
  - No operation is dropped or duplicated; results leave in order.
- Immediate mode: n = in_amt[log2(DATA_W)-1:0]. Let W = DATA_W.
  - LSL 0: data unchanged, c = cin.
  - LSL n: data << n, c = data[W-n].
  - LSR 0 means LSR W: result 0, c = data[W-1].
  - LSR n: result data >> n, c = data[n-1].
  - ASR 0 means ASR W: result all bits = data[W-1], c = data[W-1].
  - ASR n: arithmetic shift, c = data[n-1].
  - ROR 0 means RRX: result {cin, data[W-1:1]}, c = data[0].
  - ROR n: rotate right by n, c = data[n-1].
- Register mode: n = full in_amt.
  - n = 0, any type: data unchanged, c = cin.
  - LSL, n < W: as immediate. n = W: result 0, c = data[0]. n > W: result 0, c = 0.
  - LSR, n < W: as immediate. n = W: result 0, c = data[W-1]. n > W: result 0, c = 0.
  - ASR, n ≥ W: sign fill, c = data[W-1].
  - ROR, m = n mod W. If m = 0 (and n ≠ 0): data unchanged, c = data[W-1]. Otherwise rotate by m, c = data[m-1].
- Reset mid-operation: all in-flight operations are discarded. The first input accepted after reset release appears 2 cycles later.

Optional Feature:
- Macro: ARM_SHIFTER_FLAGS_EN.
- Defined:
  - out_zero is registered in stage 2 as (result == 0).
  - out_neg is registered as result[DATA_W-1].
  - Both hold under stall along with out_data.
- Undefined:
  - Both ports remain present and are tied to 0.
  - No extra logic is built.

Decomposition:
- Package arm_shift_pkg:
  - shift_type_e enum: SH_LSL=2'b00, SH_LSR=2'b01, SH_ASR=2'b10, SH_ROR=2'b11.
  - Encoding constants for in_reg_mode.
- Sub-module arm_shift_core:
  - Purely combinational: data, type, amt, reg_mode, cin -> result, cout.
  - Parametrised by DATA_W and AMT_W.
  - Built as a log2 barrel network rather than a case per amount.
  - Instantiated once, in stage 2.

Test Plan:
- Immediate LSL 4, data 0x8000_000F, cin 0 -> out 0x0000_00F0, cout 0, out_valid exactly 2 cycles after acceptance.
- Immediate ROR 0 (RRX), data 0x0000_0003, cin 1 -> out 0x8000_0001, cout 1. Immediate ASR 0, data 0x8000_0000 -> out 0xFFFF_FFFF, cout 1.
- Register LSR, data 0x8000_0000:
  - amt 32 -> out 0, cout 1.
  - amt 33 -> out 0, cout 0.
  - amt 0 with cin 1 -> out 0x8000_0000, cout 1.
- Register ROR, data 0x8000_0001:
  - amt 64 -> out 0x8000_0001, cout 1.
  - amt 33 -> out 0xC000_0000, cout 1.
- Register ASR amt 40, data 0x7000_0000 -> out 0, cout 0. Register LSL amt 32, data 0x0000_0001 -> out 0, cout 1.
- Backpressure: 3 back-to-back inputs with tags 1,2,3 while out_ready is held low for 4 cycles:
  - in_ready drops once both stages are full;
  - out_data and out_tag stay frozen;
  - after release, tags appear in order 1,2,3 with no gaps or duplicates.
  - A separate check pulses rst_n low with both stages valid: out_valid falls asynchronously and no stale result appears after release.
